// File: rtl/status_framer.sv
// Periodic telemetry framer: snapshots sample-FIFO occupancy and event counts,
// then serialises a 7-byte frame over a valid/ready byte stream.
//
// state | meaning
// IDLE  | waiting for a tick or host request
// SEND  | presenting frame byte idx_q, advancing on each accepted transfer
module status_framer #(
   parameter int unsigned PERIOD_CLKS = 12800000,
   parameter int unsigned LEVEL_WIDTH = 11,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   request,
   input  logic [LEVEL_WIDTH-1:0] fifo_level,
   input  logic                   fifo_full,
   input  logic                   fifo_empty,
   input  logic                   underrun_evt,
   input  logic                   overflow_evt,
   output logic [7:0]             tx_data_si,
   output logic                   tx_valid_si,
   input  logic                   tx_ready_si,
   output logic                   busy
);

   localparam int unsigned TIMER_W = $clog2(PERIOD_CLKS);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]         idx_q, idx_d;
   logic [7:0]         seq_q, seq_d;
   logic [7:0]         und_cnt_q, und_cnt_d;
   logic [7:0]         ovf_cnt_q, ovf_cnt_d;
   logic               missed_q, missed_d;
   logic [7:0]         frm_seq_q, frm_seq_d;
   logic [7:0]         frm_b2_q, frm_b2_d;
   logic [7:0]         frm_b3_q, frm_b3_d;
   logic [7:0]         frm_und_q, frm_und_d;
   logic [7:0]         frm_ovf_q, frm_ovf_d;
   logic [7:0]         frm_chk_q, frm_chk_d;

   logic               tick;
   logic               trigger;
   logic               xfer;
   logic [10:0]        level_11;
   logic [7:0]         snap_b2;
   logic [7:0]         und_sat;
   logic [7:0]         ovf_sat;

   assign tick     = enable && (timer_q == TIMER_W'(PERIOD_CLKS - 1));
   assign trigger  = tick || request;
   assign xfer     = (state_q == SEND) && tx_ready_si;
   assign level_11 = 11'(fifo_level);
   assign snap_b2  = {fifo_full, fifo_empty, missed_q, 2'b00, level_11[10:8]};
   assign und_sat  = (und_cnt_q == 8'hFF) ? und_cnt_q : und_cnt_q + 8'd1;
   assign ovf_sat  = (ovf_cnt_q == 8'hFF) ? ovf_cnt_q : ovf_cnt_q + 8'd1;

   always_comb begin
      timer_d = '0;
      if (enable && !tick) begin
         timer_d = timer_q + TIMER_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      seq_d     = seq_q;
      missed_d  = missed_q;
      und_cnt_d = underrun_evt ? und_sat : und_cnt_q;
      ovf_cnt_d = overflow_evt ? ovf_sat : ovf_cnt_q;
      frm_seq_d = frm_seq_q;
      frm_b2_d  = frm_b2_q;
      frm_b3_d  = frm_b3_q;
      frm_und_d = frm_und_q;
      frm_ovf_d = frm_ovf_q;
      frm_chk_d = frm_chk_q;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               frm_seq_d = seq_q;
               frm_b2_d  = snap_b2;
               frm_b3_d  = level_11[7:0];
               frm_und_d = und_cnt_q;
               frm_ovf_d = ovf_cnt_q;
               frm_chk_d = SYNC_BYTE ^ seq_q ^ snap_b2 ^ level_11[7:0]
                           ^ und_cnt_q ^ ovf_cnt_q;
               // events in the snapshot cycle open the next window
               und_cnt_d = {7'd0, underrun_evt};
               ovf_cnt_d = {7'd0, overflow_evt};
               missed_d  = 1'b0;
               idx_d     = 3'd0;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (trigger) begin
               missed_d = 1'b1;
            end
            if (xfer) begin
               if (idx_q == 3'd6) begin
                  idx_d   = 3'd0;
                  seq_d   = seq_q + 8'd1;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_data_si = 8'h00;
      if (state_q == SEND) begin
         case (idx_q)
            3'd0:    tx_data_si = SYNC_BYTE;
            3'd1:    tx_data_si = frm_seq_q;
            3'd2:    tx_data_si = frm_b2_q;
            3'd3:    tx_data_si = frm_b3_q;
            3'd4:    tx_data_si = frm_und_q;
            3'd5:    tx_data_si = frm_ovf_q;
            3'd6:    tx_data_si = frm_chk_q;
            default: tx_data_si = 8'h00;
         endcase
      end
   end

   assign tx_valid_si = (state_q == SEND);
   assign busy        = (state_q == SEND);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         idx_q     <= 3'd0;
         seq_q     <= 8'd0;
         und_cnt_q <= 8'd0;
         ovf_cnt_q <= 8'd0;
         missed_q  <= 1'b0;
         frm_seq_q <= 8'd0;
         frm_b2_q  <= 8'd0;
         frm_b3_q  <= 8'd0;
         frm_und_q <= 8'd0;
         frm_ovf_q <= 8'd0;
         frm_chk_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         idx_q     <= idx_d;
         seq_q     <= seq_d;
         und_cnt_q <= und_cnt_d;
         ovf_cnt_q <= ovf_cnt_d;
         missed_q  <= missed_d;
         frm_seq_q <= frm_seq_d;
         frm_b2_q  <= frm_b2_d;
         frm_b3_q  <= frm_b3_d;
         frm_und_q <= frm_und_d;
         frm_ovf_q <= frm_ovf_d;
         frm_chk_q <= frm_chk_d;
      end
   end

endmodule

// File: tb/tb_status_framer.sv
// Bench for status_framer: frame-level reference model checked every cycle,
// directed scenarios with literal frames, then a randomized soak.
module tb_status_framer;

   localparam int P = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        request;
   logic [10:0] fifo_level;
   logic        fifo_full;
   logic        fifo_empty;
   logic        underrun_evt;
   logic        overflow_evt;
   logic [7:0]  tx_data_si;
   logic        tx_valid_si;
   logic        tx_ready_si;
   logic        busy;

   status_framer #(.PERIOD_CLKS(P), .LEVEL_WIDTH(11), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .enable(enable), .request(request),
      .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .underrun_evt(underrun_evt), .overflow_evt(overflow_evt),
      .tx_data_si(tx_data_si), .tx_valid_si(tx_valid_si),
      .tx_ready_si(tx_ready_si), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: bytes remaining in the current frame plus window state
   int         m_timer = 0, m_seq = 0, m_und = 0, m_ovf = 0, m_rem = 0;
   bit         m_missed = 0;
   bit         m_tick, m_trig;
   logic [7:0] m_frame [7];
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic [7:0] got [$];

   always @(posedge clk) begin
      if (!rst && s_valid && tx_ready_si) got.push_back(s_data);
      if (rst) begin
         m_timer = 0; m_seq = 0; m_und = 0; m_ovf = 0; m_rem = 0; m_missed = 0;
      end else begin
         m_tick  = enable && (m_timer == P - 1);
         m_timer = enable ? (m_timer + 1) % P : 0;
         m_trig  = m_tick || request;
         if (m_rem > 0) begin
            if (m_trig) m_missed = 1;
            if (underrun_evt) m_und = (m_und < 255) ? m_und + 1 : 255;
            if (overflow_evt) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
            if (tx_ready_si) begin
               m_rem--;
               if (m_rem == 0) m_seq = (m_seq + 1) % 256;
            end
         end else if (m_trig) begin
            m_frame[0] = 8'hA5;
            m_frame[1] = 8'(m_seq);
            m_frame[2] = {fifo_full, fifo_empty, m_missed, 2'b00, fifo_level[10:8]};
            m_frame[3] = fifo_level[7:0];
            m_frame[4] = 8'(m_und);
            m_frame[5] = 8'(m_ovf);
            m_frame[6] = 8'h00;
            for (int i = 0; i < 6; i++) m_frame[6] = m_frame[6] ^ m_frame[i];
            m_und = underrun_evt ? 1 : 0;
            m_ovf = overflow_evt ? 1 : 0;
            m_missed = 0;
            m_rem = 7;
         end else begin
            if (underrun_evt) m_und = (m_und < 255) ? m_und + 1 : 255;
            if (overflow_evt) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
         end
      end
      #1;
      chk("valid", int'(tx_valid_si), int'(m_rem > 0));
      chk("busy", int'(busy), int'(m_rem > 0));
      if (m_rem > 0) chk("data", int'(tx_data_si), int'(m_frame[7 - m_rem]));
      s_valid = tx_valid_si;
      s_data  = tx_data_si;
   end

   task automatic wait_bytes(input int n, input int limit, input string nm);
      for (int i = 0; i < limit && got.size() < n; i++) @(negedge clk);
      if (got.size() < n) chk({nm, "_timeout"}, got.size(), n);
   endtask

   task automatic check_frame(input string nm,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3,
                              input logic [7:0] e4, input logic [7:0] e5,
                              input logic [7:0] e6);
      logic [7:0] e [7];
      logic [7:0] b;
      e = '{e0, e1, e2, e3, e4, e5, e6};
      wait_bytes(7, 80, nm);
      for (int i = 0; i < 7; i++) begin
         if (got.size() > 0) begin
            b = got.pop_front();
            chk($sformatf("%s_b%0d", nm, i), int'(b), int'(e[i]));
         end
      end
   endtask

   task automatic pulse_request();
      request = 1'b1;
      @(negedge clk);
      request = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
   endtask

   int nvalid;
   bit done;

   initial begin
      rst = 1'b1; enable = 1'b0; request = 1'b0; fifo_level = '0;
      fifo_full = 1'b0; fifo_empty = 1'b0; underrun_evt = 1'b0;
      overflow_evt = 1'b0; tx_ready_si = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset_valid", int'(tx_valid_si), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_data", int'(tx_data_si), 0);

      // periodic frames, ready always high
      rst = 1'b0; enable = 1'b1; fifo_level = 11'h2C3; got.delete();
      wait_bytes(14, 100, "periodic");
      enable = 1'b0;
      check_frame("per1", 8'hA5, 8'h00, 8'h02, 8'hC3, 8'h00, 8'h00, 8'h64);
      check_frame("per2", 8'hA5, 8'h01, 8'h02, 8'hC3, 8'h00, 8'h00, 8'h65);
      wait_idle();

      // event counting with saturation, then cleared window
      fifo_level = '0; fifo_empty = 1'b1;
      for (int i = 0; i < 300; i++) begin
         overflow_evt = 1'b1;
         underrun_evt = (i < 3);
         @(negedge clk);
      end
      overflow_evt = 1'b0; underrun_evt = 1'b0;
      pulse_request();
      check_frame("evt1", 8'hA5, 8'h02, 8'h40, 8'h00, 8'h03, 8'hFF, 8'h1B);
      pulse_request();
      check_frame("evt2", 8'hA5, 8'h03, 8'h40, 8'h00, 8'h00, 8'h00, 8'hE6);

      // ready asserted one cycle in three
      tx_ready_si = 1'b0;
      pulse_request();
      nvalid = 0; done = 0;
      for (int j = 0; j < 100 && !done; j++) begin
         tx_ready_si = (j % 3 == 2);
         if (tx_valid_si) nvalid++;
         @(negedge clk);
         if (!tx_valid_si) done = 1;
      end
      tx_ready_si = 1'b1;
      chk("slow_ready_cycles", nvalid, 21);
      check_frame("slow", 8'hA5, 8'h04, 8'h40, 8'h00, 8'h00, 8'h00, 8'hE1);

      // long stall: extra ticks dropped and flagged as missed
      fifo_level = 11'h2C3; fifo_empty = 1'b0; tx_ready_si = 1'b0; enable = 1'b1;
      repeat (40) @(negedge clk);
      tx_ready_si = 1'b1;
      wait_bytes(21, 150, "stall");
      enable = 1'b0;
      check_frame("stall1", 8'hA5, 8'h05, 8'h02, 8'hC3, 8'h00, 8'h00, 8'h61);
      check_frame("stall2", 8'hA5, 8'h06, 8'h22, 8'hC3, 8'h00, 8'h00, 8'h42);
      check_frame("stall3", 8'hA5, 8'h07, 8'h02, 8'hC3, 8'h00, 8'h00, 8'h63);
      wait_idle();
      got.delete();

      // request with enable low: one frame, timer parked at 0
      fifo_level = 11'h3FF; fifo_full = 1'b1;
      pulse_request();
      wait_bytes(7, 40, "req_only");
      repeat (30) @(negedge clk);
      chk("req_only_count", got.size(), 7);
      chk("timer_idle", int'(dut.timer_q), 0);
      check_frame("req", 8'hA5, 8'h08, 8'h83, 8'hFF, 8'h00, 8'h00, 8'hD1);

      // request coincident with tick
      enable = 1'b1;
      repeat (15) @(negedge clk);
      request = 1'b1;
      @(negedge clk);
      request = 1'b0; enable = 1'b0;
      repeat (40) @(negedge clk);
      chk("coincident_count", got.size(), 7);
      check_frame("coin", 8'hA5, 8'h09, 8'h83, 8'hFF, 8'h00, 8'h00, 8'hD0);

      // reset after b3 accepted
      pulse_request();
      wait_bytes(4, 20, "pre_rst");
      tx_ready_si = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", int'(tx_valid_si), 0);
      chk("rst_mid_busy", int'(busy), 0);
      rst = 1'b0; tx_ready_si = 1'b1; got.delete();
      pulse_request();
      check_frame("post_rst", 8'hA5, 8'h00, 8'h83, 8'hFF, 8'h00, 8'h00, 8'hD9);

      // randomized soak against the model
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         request      = ($urandom_range(0, 29) == 0);
         tx_ready_si  = ($urandom_range(0, 3) != 0);
         underrun_evt = ($urandom_range(0, 7) == 0);
         overflow_evt = ($urandom_range(0, 7) == 0);
         fifo_level   = 11'($urandom_range(0, 1024));
         fifo_full    = $urandom_range(0, 1) == 1;
         fifo_empty   = $urandom_range(0, 1) == 1;
         @(negedge clk);
      end
      rst = 1'b0; request = 1'b0; enable = 1'b0;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
